// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit between EXU and writeback: one op in flight, valid/ready handshakes on every side.
// Optional misaligned-access trap: define YSYX_23060332_LSU_MISALIGN_CHK_EN (adds port lsu_misalign).
// state    | meaning
// IDLE     | ready for a new EXU op
// REQ      | memory request presented, waiting for mem_req_ready
// WAIT_RSP | waiting for read data or write ack
// WB       | result presented to writeback, waiting for wb_ready
module ysyx_23060332_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_func3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [4:0]        ex_waddr,
  input  logic              ex_reg_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              mem_rsp_ready,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_wen
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
  ,
  output logic              lsu_misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_WB} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]        req_wmask_q, req_wmask_d;
  logic              req_wen_q, req_wen_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              reg_wen_q, reg_wen_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_wen_q, res_wen_d;

  logic [1:0]        ex_off;
  logic              ex_is_mem;
  logic [3:0]        fmt_wmask;
  logic [DATA_W-1:0] fmt_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  assign ex_off    = ex_addr[1:0];
  assign ex_is_mem = ex_is_load | ex_is_store;

  // 4-bit shifts clip a misaligned half mask to the word's byte lanes
  always_comb begin
    fmt_wmask = 4'b0000;
    fmt_wdata = '0;
    if (ex_is_store) begin
      case (ex_func3)
        3'b000: begin
          fmt_wmask = 4'b0001 << ex_off;
          fmt_wdata = {(DATA_W/8){ex_wdata[7:0]}};
        end
        3'b001: begin
          fmt_wmask = 4'b0011 << ex_off;
          fmt_wdata = {(DATA_W/16){ex_wdata[15:0]}};
        end
        3'b010: begin
          fmt_wmask = 4'b1111;
          fmt_wdata = ex_wdata;
        end
        default: ;
      endcase
    end else if (ex_is_load) begin
      case (ex_func3)
        3'b000, 3'b100: fmt_wmask = 4'b0001 << ex_off;
        3'b001, 3'b101: fmt_wmask = 4'b0011 << ex_off;
        3'b010:         fmt_wmask = 4'b1111;
        default:        fmt_wmask = 4'b0000;
      endcase
    end
  end

`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
  logic mis_q, mis_d;
  logic ex_misaligned;

  always_comb begin
    ex_misaligned = 1'b0;
    case (ex_func3)
      3'b001:  ex_misaligned = ex_off[0];
      3'b101:  ex_misaligned = ex_off[0] & ~ex_is_store;
      3'b010:  ex_misaligned = (ex_off != 2'b00);
      default: ex_misaligned = 1'b0;
    endcase
  end
`endif

  always_comb begin
    ld_half = off_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (off_q)
      2'd1:    ld_byte = mem_rsp_rdata[15:8];
      2'd2:    ld_byte = mem_rsp_rdata[23:16];
      2'd3:    ld_byte = mem_rsp_rdata[31:24];
      default: ld_byte = mem_rsp_rdata[7:0];
    endcase
    case (func3_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_rsp_rdata;
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    req_wen_d   = req_wen_q;
    is_load_d   = is_load_q;
    func3_d     = func3_q;
    off_d       = off_q;
    waddr_d     = waddr_q;
    reg_wen_d   = reg_wen_q;
    res_data_d  = res_data_q;
    res_wen_d   = res_wen_q;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
    mis_d       = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          req_addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
          req_wdata_d = fmt_wdata;
          req_wmask_d = fmt_wmask;
          req_wen_d   = ex_is_store;
          is_load_d   = ex_is_load & ~ex_is_store;
          func3_d     = ex_func3;
          off_d       = ex_off;
          waddr_d     = ex_waddr;
          reg_wen_d   = ex_reg_wen;
          if (ex_is_mem) begin
            state_d    = S_REQ;
            res_data_d = '0;
            res_wen_d  = 1'b0;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
            if (ex_misaligned) begin
              state_d = S_WB;
              mis_d   = 1'b1;
            end
`endif
          end else begin
            state_d    = S_WB;
            res_data_d = ex_alu_result;
            res_wen_d  = ex_reg_wen;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_d = S_WB;
          if (is_load_q) begin
            res_data_d = ld_data;
            res_wen_d  = reg_wen_q;
          end else begin
            res_data_d = '0;
            res_wen_d  = 1'b0;
          end
        end
      end
      S_WB: begin
        if (wb_ready) begin
          state_d = S_IDLE;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
          mis_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      req_wen_q   <= 1'b0;
      is_load_q   <= 1'b0;
      func3_q     <= '0;
      off_q       <= '0;
      waddr_q     <= '0;
      reg_wen_q   <= 1'b0;
      res_data_q  <= '0;
      res_wen_q   <= 1'b0;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      req_wen_q   <= req_wen_d;
      is_load_q   <= is_load_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      waddr_q     <= waddr_d;
      reg_wen_q   <= reg_wen_d;
      res_data_q  <= res_data_d;
      res_wen_q   <= res_wen_d;
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign ex_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_wen   = mem_req_valid & req_wen_q;
  assign mem_req_addr  = mem_req_valid ? req_addr_q : '0;
  assign mem_req_wdata = mem_req_valid ? req_wdata_q : '0;
  assign mem_req_wmask = mem_req_valid ? MASK_W'(req_wmask_q) : '0;
  assign mem_rsp_ready = (state_q == S_WAIT_RSP);
  assign wb_valid      = (state_q == S_WB);
  assign wb_waddr      = wb_valid ? waddr_q : '0;
  assign wb_wdata      = wb_valid ? res_data_q : '0;
  // x0 is never written, whatever the op asked for
  assign wb_wen        = wb_valid & res_wen_q & (waddr_q != 5'd0);
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
  assign lsu_misalign  = wb_valid & mis_q;
`endif

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Scoreboard bench for ysyx_23060332_lsu: expected requests/writebacks queued at issue, checked on output.
module tb_ysyx_23060332_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_reg_wen;
  logic [2:0]  ex_func3;
  logic [31:0] ex_addr, ex_wdata, ex_alu_result;
  logic [4:0]  ex_waddr;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid, wb_ready, wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lsu_misalign;

  always #5 clk = ~clk;

  ysyx_23060332_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_func3(ex_func3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu_result(ex_alu_result),
    .ex_waddr(ex_waddr), .ex_reg_wen(ex_reg_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_ready(mem_rsp_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_wen(wb_wen)
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
    , .lsu_misalign(lsu_misalign)
`endif
  );
`ifndef YSYX_23060332_LSU_MISALIGN_CHK_EN
  assign lsu_misalign = 1'b0;
`endif

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, alu;
    logic [4:0]  rd;
    logic        rwen;
    logic [31:0] rsp;
    logic        mem;
    logic [31:0] e_addr, e_wdata;
    logic [7:0]  e_mask;
    logic [31:0] e_wb;
    logic        e_wbwen, e_mis;
    int          req_stall, wb_stall;
  } op_t;

  typedef struct { logic [31:0] addr, wdata; logic [7:0] mask; logic wen; } req_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic wen, mis; } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edges = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  function automatic op_t mk_op(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu,
                                input logic [4:0] rd, input logic rwen, input logic [31:0] rsp,
                                input logic mem, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [7:0] e_mask, input logic [31:0] e_wb, input logic e_wbwen,
                                input int rs, input int ws);
    op_t o;
    o.ld = ld; o.st = st; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.alu = alu;
    o.rd = rd; o.rwen = rwen; o.rsp = rsp; o.mem = mem; o.e_addr = e_addr; o.e_wdata = e_wdata;
    o.e_mask = e_mask; o.e_wb = e_wb; o.e_wbwen = e_wbwen; o.e_mis = 1'b0;
    o.req_stall = rs; o.wb_stall = ws;
    return o;
  endfunction

  task automatic run_op(input op_t op);
    req_t r;
    wb_t  w;
    int   guard;
    check_eq("ex_ready_idle", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_is_load = op.ld; ex_is_store = op.st; ex_func3 = op.f3;
    ex_addr = op.addr; ex_wdata = op.wdata; ex_alu_result = op.alu;
    ex_waddr = op.rd; ex_reg_wen = op.rwen;
    if (op.mem) begin
      r.addr = op.e_addr; r.wdata = op.e_wdata; r.mask = op.e_mask; r.wen = op.st;
      req_q.push_back(r);
    end
    w.rd = op.rd; w.data = op.e_wb; w.wen = op.e_wbwen; w.mis = op.e_mis;
    wb_q.push_back(w);
    edges = 0;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_func3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_alu_result = '0; ex_waddr = '0; ex_reg_wen = 1'b0;
    if (op.mem) begin
      check_eq("req_valid", 32'(mem_req_valid), 32'd1);
      r = req_q.pop_front();
      for (int i = 0; i <= op.req_stall; i++) begin
        check_eq("req_addr", mem_req_addr, r.addr);
        check_eq("req_wdata", mem_req_wdata, r.wdata);
        check_eq("req_wmask", 32'(mem_req_wmask), 32'(r.mask));
        check_eq("req_wen", 32'(mem_req_wen), 32'(r.wen));
        check_eq("ex_ready_busy", 32'(ex_ready), 32'd0);
        if (i < op.req_stall) begin
          step();
          check_eq("req_valid_held", 32'(mem_req_valid), 32'd1);
        end
      end
      // a response beat during the request handshake must be ignored
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = ~op.rsp;
      step();
      mem_req_ready = 1'b0; mem_rsp_rdata = op.rsp;
      check_eq("req_valid_drop", 32'(mem_req_valid), 32'd0);
      check_eq("rsp_ready", 32'(mem_rsp_ready), 32'd1);
      step();
      mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    end else begin
      check_eq("no_req", 32'(mem_req_valid), 32'd0);
    end
    guard = 0;
    while (!wb_valid && guard < 20) begin
      step();
      guard++;
    end
    if (!wb_valid) begin
      check_eq("wb_timeout", 32'(wb_valid), 32'd1);
      void'(wb_q.pop_front());
      return;
    end
    check_eq("wb_latency", 32'(edges), 32'(op.mem ? 3 + op.req_stall : 1));
    w = wb_q.pop_front();
    for (int j = 0; j <= op.wb_stall; j++) begin
      check_eq("wb_valid", 32'(wb_valid), 32'd1);
      check_eq("wb_waddr", 32'(wb_waddr), 32'(w.rd));
      check_eq("wb_wdata", wb_wdata, w.data);
      check_eq("wb_wen", 32'(wb_wen), 32'(w.wen));
      check_eq("lsu_misalign", 32'(lsu_misalign), 32'(w.mis));
      check_eq("ex_ready_wb", 32'(ex_ready), 32'd0);
      if (j < op.wb_stall) step();
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check_eq("wb_done", 32'(wb_valid), 32'd0);
    check_eq("ex_ready_back", 32'(ex_ready), 32'd1);
  endtask

  task automatic check_all_idle(input string tag);
    check_eq({tag, "_ex_ready"}, 32'(ex_ready), 32'd1);
    check_eq({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check_eq({tag, "_req_wen"}, 32'(mem_req_wen), 32'd0);
    check_eq({tag, "_req_addr"}, mem_req_addr, 32'd0);
    check_eq({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
    check_eq({tag, "_req_wmask"}, 32'(mem_req_wmask), 32'd0);
    check_eq({tag, "_rsp_ready"}, 32'(mem_rsp_ready), 32'd0);
    check_eq({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check_eq({tag, "_wb_waddr"}, 32'(wb_waddr), 32'd0);
    check_eq({tag, "_wb_wdata"}, wb_wdata, 32'd0);
    check_eq({tag, "_wb_wen"}, 32'(wb_wen), 32'd0);
    check_eq({tag, "_misalign"}, 32'(lsu_misalign), 32'd0);
  endtask

  op_t ops[$];
  op_t mis_op;

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_func3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_alu_result = '0; ex_waddr = '0; ex_reg_wen = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; wb_ready = 1'b0;
    repeat (2) step();
    check_all_idle("reset");
    rst_n = 1'b1;
    step();

    //             ld   st   f3      addr          wdata         alu           rd  rwen rsp           mem  e_addr        e_wdata       mask   e_wb          wen  rs ws
    ops.push_back(mk_op(0, 0, 3'b000, 32'h0,        32'h0,        32'h0000_0005, 3, 1, 32'h0,        0, 32'h0,        32'h0,        8'h00, 32'h0000_0005, 1, 0, 0));
    ops.push_back(mk_op(0, 0, 3'b000, 32'h0,        32'h0,        32'h0000_1234, 0, 1, 32'h0,        0, 32'h0,        32'h0,        8'h00, 32'h0000_1234, 0, 0, 1));
    ops.push_back(mk_op(0, 0, 3'b000, 32'h0,        32'h0,        32'hFFFF_0000, 7, 0, 32'h0,        0, 32'h0,        32'h0,        8'h00, 32'hFFFF_0000, 0, 0, 0));
    ops.push_back(mk_op(0, 1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 32'h0,       5, 0, 32'h0,        1, 32'h8000_0000, 32'hABAB_ABAB, 8'h08, 32'h0,        0, 0, 0));
    ops.push_back(mk_op(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0,       6, 0, 32'h0,        1, 32'h8000_0000, 32'hBEEF_BEEF, 8'h0C, 32'h0,        0, 1, 0));
    ops.push_back(mk_op(0, 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,       0, 0, 32'h0,        1, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F, 32'h0,        0, 0, 0));
    ops.push_back(mk_op(1, 0, 3'b000, 32'h8000_0002, 32'h0,        32'h0,       10, 1, 32'h0080_0000, 1, 32'h8000_0000, 32'h0,        8'h04, 32'hFFFF_FF80, 1, 0, 0));
    ops.push_back(mk_op(1, 0, 3'b100, 32'h8000_0002, 32'h0,        32'h0,       11, 1, 32'h0080_0000, 1, 32'h8000_0000, 32'h0,        8'h04, 32'h0000_0080, 1, 0, 0));
    ops.push_back(mk_op(1, 0, 3'b001, 32'h8000_0002, 32'h0,        32'h0,       12, 1, 32'h8001_0000, 1, 32'h8000_0000, 32'h0,        8'h0C, 32'hFFFF_8001, 1, 1, 1));
    ops.push_back(mk_op(1, 0, 3'b101, 32'h8000_0000, 32'h0,        32'h0,       13, 1, 32'h1234_F00D, 1, 32'h8000_0000, 32'h0,        8'h03, 32'h0000_F00D, 1, 0, 0));
    ops.push_back(mk_op(1, 0, 3'b010, 32'h8000_0008, 32'h0,        32'h0,       14, 1, 32'hCAFE_BABE, 1, 32'h8000_0008, 32'h0,        8'h0F, 32'hCAFE_BABE, 1, 5, 3));
    ops.push_back(mk_op(1, 0, 3'b000, 32'h8000_0001, 32'h0,        32'h0,       15, 1, 32'h0000_7F00, 1, 32'h8000_0000, 32'h0,        8'h02, 32'h0000_007F, 1, 0, 0));
    ops.push_back(mk_op(1, 0, 3'b100, 32'h8000_0003, 32'h0,        32'h0,       16, 1, 32'hAB00_0000, 1, 32'h8000_0000, 32'h0,        8'h08, 32'h0000_00AB, 1, 0, 0));
    ops.push_back(mk_op(0, 1, 3'b011, 32'h8000_0010, 32'h0000_0055, 32'h0,       0, 0, 32'h0,        1, 32'h8000_0010, 32'h0,        8'h00, 32'h0,        0, 0, 0));
    ops.push_back(mk_op(1, 1, 3'b010, 32'h8000_0014, 32'h0BAD_F00D, 32'h0,       17, 1, 32'h7777_7777, 1, 32'h8000_0014, 32'h0BAD_F00D, 8'h0F, 32'h0,       0, 0, 0));
    ops.push_back(mk_op(1, 0, 3'b010, 32'h8000_0018, 32'h0,        32'h0,       0, 1, 32'h0000_0099, 1, 32'h8000_0018, 32'h0,        8'h0F, 32'h0000_0099, 0, 0, 0));
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
    mis_op = mk_op(1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 18, 1, 32'h1122_3344, 0, 32'h0, 32'h0, 8'h00, 32'h0, 0, 0, 0);
    mis_op.e_mis = 1'b1;
`else
    mis_op = mk_op(1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 18, 1, 32'h1122_3344, 1, 32'h8000_0000, 32'h0, 8'h0F, 32'h1122_3344, 1, 0, 0);
`endif
    ops.push_back(mis_op);

    foreach (ops[k]) run_op(ops[k]);

    // reset while waiting for a response: outputs clear at once, a late response is dropped
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_func3 = 3'b010; ex_addr = 32'h8000_0020; ex_waddr = 5'd9; ex_reg_wen = 1'b1;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_func3 = '0; ex_addr = '0; ex_waddr = '0; ex_reg_wen = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check_eq("rst_pre_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_idle("async_rst");
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555_5555;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      check_eq("late_rsp_no_wb", 32'(wb_valid), 32'd0);
      step();
    end
    run_op(ops[0]);

    check_eq("req_q_empty", 32'(req_q.size()), 32'd0);
    check_eq("wb_q_empty", 32'(wb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
